// File: rtl/ide_bridge_pkg.sv
// ide_bridge_pkg: shared constants and FSM encoding for ide_mgmt_bridge.
//   CMD_*       command bytes that open an MCU frame
//   IDE_ADDR_W  width of the gayle mgmt register address
//   state_e     bridge frame state
package ide_bridge_pkg;

   localparam int         IDE_ADDR_W = 5;

   localparam logic [7:0] CMD_STATUS = 8'h80;
   localparam logic [7:0] CMD_REG_RD = 8'h81;
   localparam logic [7:0] CMD_REG_WR = 8'h82;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_RD,
      S_ADDR_WR,
      S_RD_HI,
      S_RD_LO,
      S_WR_HI,
      S_WR_LO,
      S_IGNORE,
      S_STAT1,
      S_STAT2
   } state_e;

endpackage

// File: rtl/ide_mgmt_bridge.sv
// ide_mgmt_bridge: MCU byte channel <-> gayle IDE management port.
//   clk, reset        system clock, synchronous active-high reset
//   mcu_strobe/start  byte valid / byte is a frame-opening command
//   mcu_din/dout      MCU byte in, response byte out (updated on each strobe)
//   mcu_attn          pending ide_req activity event
//   ide_req           gayle request bits, [2:0] port 0, [5:3] port 1
//   ide_address       mgmt register address (bit 4 = port)
//   ide_read/write    single-cycle strobes, 1 clk after the MCU strobe
//   ide_writedata     assembled 16-bit write word
//   ide_readdata      read word, valid 1 clk after ide_read
module ide_mgmt_bridge
   import ide_bridge_pkg::*;
#(
   parameter int MIN_GAP = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mcu_strobe,
   input  logic                  mcu_start,
   input  logic [7:0]            mcu_din,
   output logic [7:0]            mcu_dout,
   output logic                  mcu_attn,
   input  logic [5:0]            ide_req,
   output logic [IDE_ADDR_W-1:0] ide_address,
   output logic                  ide_read,
   output logic                  ide_write,
   output logic [15:0]           ide_writedata,
   input  logic [15:0]           ide_readdata
);

   // Prefetched data lands 2 clks after the RD_LO strobe; the next RD_HI
   // strobe must come at least 3 clks later to see it.
   if (MIN_GAP < 3) begin : g_gap_check
      $error("ide_mgmt_bridge: MIN_GAP must be >= 3 for read prefetch");
   end

   state_e                  state_q, state_d;
   logic [7:0]              dout_q, dout_d;
   logic                    evt_q, evt_d, evt_clr;
   logic [5:0]              req_q;
   logic [IDE_ADDR_W-1:0]   addr_q, addr_d;
   logic                    rd_q, rd_d;
   logic                    wr_q, wr_d;
   logic [15:0]             wdata_q, wdata_d;
   logic [7:0]              hi_q, hi_d;
   logic                    cap_q;
   logic [15:0]             rd_word_q;
   logic                    evt_set;

   // Any rising request bit (zero->nonzero is a special case of this).
   assign evt_set = |(ide_req & ~req_q);
   // A new event in the clearing clk survives the clear.
   assign evt_d   = evt_set | (evt_q & ~evt_clr);

   always_comb begin
      state_d = state_q;
      dout_d  = dout_q;
      addr_d  = addr_q;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      wdata_d = wdata_q;
      hi_d    = hi_q;
      evt_clr = 1'b0;
      if (mcu_strobe) begin
         dout_d = 8'h00;
         if (mcu_start) begin
            // A command aborts whatever frame was open; a pending high byte
            // is simply never paired.
            case (mcu_din)
               CMD_STATUS: begin
                  state_d = S_STAT1;
                  dout_d  = {2'b00, req_q};
               end
               CMD_REG_RD: state_d = S_ADDR_RD;
               CMD_REG_WR: state_d = S_ADDR_WR;
               default:    state_d = S_IGNORE;
            endcase
         end else begin
            case (state_q)
               S_ADDR_RD: begin
                  addr_d  = mcu_din[IDE_ADDR_W-1:0];
                  rd_d    = 1'b1;
                  state_d = S_RD_HI;
               end
               S_ADDR_WR: begin
                  addr_d  = mcu_din[IDE_ADDR_W-1:0];
                  state_d = S_WR_HI;
               end
               S_RD_HI: begin
                  dout_d  = rd_word_q[15:8];
                  state_d = S_RD_LO;
               end
               S_RD_LO: begin
                  dout_d  = rd_word_q[7:0];
                  rd_d    = 1'b1;  // prefetch next word, same address
                  state_d = S_RD_HI;
               end
               S_WR_HI: begin
                  hi_d    = mcu_din;
                  state_d = S_WR_LO;
               end
               S_WR_LO: begin
                  wdata_d = {hi_q, mcu_din};
                  wr_d    = 1'b1;
                  state_d = S_WR_HI;
               end
               S_STAT1: begin
                  dout_d  = {7'b0, evt_q};
                  evt_clr = 1'b1;
                  state_d = S_STAT2;
               end
               default: ;  // IDLE, IGNORE, STAT2: reply 0x00, hold state
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         dout_q    <= 8'h00;
         evt_q     <= 1'b0;
         req_q     <= 6'b0;
         addr_q    <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         wdata_q   <= 16'h0000;
         hi_q      <= 8'h00;
         cap_q     <= 1'b0;
         rd_word_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         evt_q   <= evt_d;
         req_q   <= ide_req;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         hi_q    <= hi_d;
         // Read data is valid the clk after ide_read. A prefetch left over
         // from an aborted frame is captured but never returned: RD_HI is
         // only re-entered through an address strobe that issues a fresh read.
         cap_q   <= rd_q;
         if (cap_q) rd_word_q <= ide_readdata;
      end
   end

   assign mcu_dout      = dout_q;
   assign mcu_attn      = evt_q;
   assign ide_address   = addr_q;
   assign ide_read      = rd_q;
   assign ide_write     = wr_q;
   assign ide_writedata = wdata_q;

endmodule

// File: tb/tb_ide_mgmt_bridge.sv
// tb_ide_mgmt_bridge: directed + randomized checks of ide_mgmt_bridge
// against a frame-level reference model (byte/word queues, event flag).
module tb_ide_mgmt_bridge;
   import ide_bridge_pkg::*;

   logic        clk = 1'b0;
   logic        reset, mcu_strobe, mcu_start;
   logic [7:0]  mcu_din, mcu_dout;
   logic        mcu_attn;
   logic [5:0]  ide_req;
   logic [4:0]  ide_address;
   logic        ide_read, ide_write;
   logic [15:0] ide_writedata, ide_readdata;

   always #5 clk = ~clk;

   ide_mgmt_bridge #(.MIN_GAP(3)) dut (
      .clk(clk), .reset(reset),
      .mcu_strobe(mcu_strobe), .mcu_start(mcu_start),
      .mcu_din(mcu_din), .mcu_dout(mcu_dout), .mcu_attn(mcu_attn),
      .ide_req(ide_req), .ide_address(ide_address),
      .ide_read(ide_read), .ide_write(ide_write),
      .ide_writedata(ide_writedata), .ide_readdata(ide_readdata)
   );

   int n_pass = 0, n_chk = 0, n_fail = 0;
   int n_rd = 0, n_wr = 0, n_bad = 0;
   logic prev_pulse = 1'b0;
   logic rd_pend = 1'b0;
   logic [15:0] rd_next;
   logic [15:0] rdq[$];        // words the gayle model returns, in order
   logic [15:0] exp_words[$];  // words a read frame should deliver
   logic [7:0]  wbytes[$];     // bytes a write frame sends
   logic        m_evt;         // reference attention flag

   logic [7:0]  got_dout;
   logic        got_wr, got_rd;
   logic [15:0] got_wd;
   logic [4:0]  got_addr;

   // gayle model: read data valid only in the clk after ide_read, X otherwise
   always @(negedge clk) begin
      ide_readdata = rd_pend ? rd_next : 16'hxxxx;
      rd_pend = 1'b0;
      if (ide_read === 1'b1) begin
         n_rd++;
         rd_pend = 1'b1;
         rd_next = (rdq.size() > 0) ? rdq.pop_front() : 16'($urandom);
      end
      if (ide_write === 1'b1) n_wr++;
      if ((ide_read && ide_write) || ((ide_read || ide_write) && prev_pulse)) n_bad++;
      prev_pulse = ide_read | ide_write;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One MCU strobe; samples the response the clk after it.
   task automatic send(input logic st, input logic [7:0] b);
      @(negedge clk);
      mcu_strobe = 1'b1; mcu_start = st; mcu_din = b;
      @(negedge clk);
      mcu_strobe = 1'b0; mcu_start = 1'b0; mcu_din = 8'($urandom);
      got_dout = mcu_dout; got_wr = ide_write; got_wd = ide_writedata;
      got_rd = ide_read; got_addr = ide_address;
      repeat ($urandom_range(2, 4)) @(negedge clk);
   endtask

   task automatic set_req(input logic [5:0] v);
      if ((v & ~ide_req) != 6'b0) m_evt = 1'b1;
      ide_req = v;
   endtask

   task automatic status_frame();
      send(1'b1, CMD_STATUS);
      check("stat_req", got_dout, {2'b00, ide_req});
      send(1'b0, 8'($urandom));
      check("stat_evt", got_dout, m_evt);
      m_evt = 1'b0;
      check("attn_clr", mcu_attn, 1'b0);
   endtask

   task automatic rd_frame(input logic [4:0] a);
      int n0, nw;
      nw = exp_words.size();
      rdq.delete();
      foreach (exp_words[i]) rdq.push_back(exp_words[i]);
      rdq.push_back(16'($urandom));  // trailing prefetch
      n0 = n_rd;
      send(1'b1, CMD_REG_RD);
      send(1'b0, {3'($urandom), a});
      check("rd_addr", got_addr, a);
      check("rd_issue", got_rd, 1'b1);
      for (int i = 0; i < nw; i++) begin
         send(1'b0, 8'($urandom));
         check("rd_hi", got_dout, exp_words[i][15:8]);
         send(1'b0, 8'($urandom));
         check("rd_lo", got_dout, exp_words[i][7:0]);
         check("rd_prefetch", got_rd, 1'b1);
      end
      repeat (3) @(negedge clk);
      check("rd_count", n_rd - n0, nw + 1);
   endtask

   task automatic wr_frame(input logic [4:0] a, input bit abort);
      int n0, nw;
      logic [7:0] hi, lo;
      nw = wbytes.size() / 2;
      n0 = n_wr;
      send(1'b1, CMD_REG_WR);
      send(1'b0, {3'($urandom), a});
      check("wr_addr", got_addr, a);
      for (int i = 0; i < nw; i++) begin
         hi = wbytes[2*i]; lo = wbytes[2*i+1];
         send(1'b0, hi);
         check("wr_hi_nowr", got_wr, 1'b0);
         send(1'b0, lo);
         check("wr_strobe", got_wr, 1'b1);
         check("wr_data", got_wd, {hi, lo});
         check("wr_addr_hold", got_addr, a);
      end
      if (abort) begin
         send(1'b0, 8'($urandom));
         send(1'b1, 8'h00);  // unknown command -> IGNORE
         check("abort_nowr", got_wr, 1'b0);
         send(1'b0, 8'($urandom));
         check("ignore_dout", got_dout, 8'h00);
      end
      repeat (3) @(negedge clk);
      check("wr_count", n_wr - n0, nw);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_dout"}, mcu_dout, 8'h00);
      check({tag, "_attn"}, mcu_attn, 1'b0);
      check({tag, "_rd"}, ide_read, 1'b0);
      check({tag, "_wr"}, ide_write, 1'b0);
      check({tag, "_addr"}, ide_address, 5'h00);
      check({tag, "_wdata"}, ide_writedata, 16'h0000);
   endtask

   initial begin
      int n0;
      reset = 1'b1; mcu_strobe = 1'b0; mcu_start = 1'b0; mcu_din = 8'h00;
      ide_req = 6'b0; m_evt = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;

      // request activity raises attention; STATUS reports and clears it
      set_req(6'b000101);
      repeat (2) @(negedge clk);
      check("attn_set", mcu_attn, m_evt);
      send(1'b1, CMD_STATUS);
      check("stat_05", got_dout, 8'h05);
      send(1'b0, 8'h00);
      check("stat_evt1", got_dout, 8'h01);
      m_evt = 1'b0;
      check("attn_after", mcu_attn, 1'b0);
      send(1'b0, 8'h00);
      check("stat2_zero", got_dout, 8'h00);

      // register read stream
      exp_words = '{16'hBEEF, 16'h1234};
      rd_frame(5'h13);

      // register write stream
      wbytes = '{8'hAB, 8'hCD, 8'h01, 8'h02};
      wr_frame(5'h00, 1'b0);

      // STATUS aborts a half-written word
      n0 = n_wr;
      send(1'b1, CMD_REG_WR);
      send(1'b0, 8'h05);
      send(1'b0, 8'h77);
      status_frame();
      repeat (3) @(negedge clk);
      check("abort_wcount", n_wr - n0, 0);

      // request rise coincides with STAT1 read, prior evt = 0
      set_req(6'b000000);
      send(1'b1, CMD_STATUS);
      check("race0_req", got_dout, 8'h00);
      @(negedge clk);
      mcu_strobe = 1'b1; ide_req = 6'b100000;
      @(negedge clk);
      mcu_strobe = 1'b0;
      check("race0_dout", mcu_dout, 8'h00);
      m_evt = 1'b1;
      repeat (2) @(negedge clk);
      check("race0_attn", mcu_attn, 1'b1);

      // same with prior evt = 1
      send(1'b1, CMD_STATUS);
      check("race1_req", got_dout, 8'h20);
      @(negedge clk);
      mcu_strobe = 1'b1; ide_req = 6'b110000;
      @(negedge clk);
      mcu_strobe = 1'b0;
      check("race1_dout", mcu_dout, 8'h01);
      repeat (2) @(negedge clk);
      check("race1_attn", mcu_attn, 1'b1);
      status_frame();

      // reset while in RD_LO
      rdq.delete();
      rdq.push_back(16'hA55A);
      send(1'b1, CMD_REG_RD);
      send(1'b0, 8'h07);
      send(1'b0, 8'h00);
      check("rst_rd_hi", got_dout, 8'hA5);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("midrst");
      reset = 1'b0;
      m_evt = (ide_req != 6'b0);  // registered req restarts from zero
      repeat (2) @(negedge clk);
      check("midrst_attn", mcu_attn, m_evt);
      status_frame();

      // randomized frames
      for (int it = 0; it < 24; it++) begin
         case ($urandom_range(0, 2))
            0: begin
               set_req(6'($urandom));
               status_frame();
            end
            1: begin
               exp_words.delete();
               repeat ($urandom_range(1, 3)) exp_words.push_back(16'($urandom));
               rd_frame(5'($urandom));
            end
            default: begin
               wbytes.delete();
               repeat (2 * $urandom_range(1, 3)) wbytes.push_back(8'($urandom));
               wr_frame(5'($urandom), bit'($urandom_range(0, 1)));
            end
         endcase
      end

      check("strobe_rules", n_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
